// File: rtl/adc_pkg.sv
// Shared definitions for the LTC2308 serial ADC controller.
//   ADC_W       conversion result width
//   CFG_W       width of the configuration word shifted out on SDI
//   adc_state_t frame sequencer states
//   cfg_word()  builds the single-ended, unipolar, no-sleep config word
package adc_pkg;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned CFG_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    WAIT,
    SHIFT,
    DONE
  } adc_state_t;

  // {S/D, O/S, S1, S0, UNI, SLP}; the channel select bits are not in
  // binary order on the wire, O/S carries the channel LSB.
  function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator for the ADC serial port.
//   clk   in   system clock
//   rst   in   synchronous reset, active-high
//   en    in   run the clock; when low SCK is forced low and the phase restarts
//   sck   out  SPI clock, idles low, each half-period SCK_HALF clk cycles
//   rise  out  strobe on the clk cycle whose closing edge raises sck
//   fall  out  strobe on the clk cycle whose closing edge lowers sck
module spi_sck_gen #(
  parameter int unsigned SCK_HALF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  logic [7:0] half_cnt;
  logic       half_end;

  assign half_end = en && (half_cnt == 8'(SCK_HALF - 1));
  assign rise     = half_end && !sck;
  assign fall     = half_end && sck;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      half_cnt <= '0;
      sck      <= 1'b0;
    end else if (half_end) begin
      half_cnt <= '0;
      sck      <= ~sck;
    end else begin
      half_cnt <= half_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/adc_ltc2308_ctrl.sv
// Periodic LTC2308 conversion controller with power-of-two averaging.
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   enable      in   run periodic conversions; when dropped the current frame completes
//   adc_convst  out  conversion start, high for 2 clk per frame
//   adc_sck     out  SPI clock, idles low
//   adc_sdi     out  config word to the ADC, MSB first
//   adc_sdo     in   conversion data from the ADC, MSB first
//   adc_dout    out  averaged 12-bit code, held between updates (4095 after reset)
//   dout_valid  out  one-cycle pulse coincident with a new adc_dout value
//   busy        out  high while a frame is in progress
module adc_ltc2308_ctrl
  import adc_pkg::*;
#(
  parameter int unsigned SCK_HALF      = 2,
  parameter int unsigned CONV_CYCLES   = 80,
  parameter int unsigned SAMPLE_PERIOD = 50000,
  parameter logic [2:0]  CHANNEL       = 3'd0,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             adc_convst,
  output logic             adc_sck,
  output logic             adc_sdi,
  input  logic             adc_sdo,
  output logic [ADC_W-1:0] adc_dout,
  output logic             dout_valid,
  output logic             busy
);

  localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
  localparam int unsigned TMR_W = $clog2(CONV_CYCLES + 2);
  localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  adc_state_t       state, state_next;
  logic [PER_W-1:0] per_cnt;
  logic             tick;
  logic [TMR_W-1:0] tmr;
  logic [3:0]       fall_cnt;
  logic [ADC_W-1:0] rx_sr;
  logic [ADC_W-1:0] tx_sr;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] smp_cnt;
  logic             sck_en;
  logic             sck_rise;
  logic             sck_fall;

  assign tick       = enable && (per_cnt == '0);
  assign sck_en     = (state == SHIFT);
  assign adc_convst = (state == CONVST);
  assign busy       = (state != IDLE);
  assign adc_sdi    = tx_sr[ADC_W-1];
  assign acc_sum    = acc + ACC_W'(rx_sr);

  spi_sck_gen #(
    .SCK_HALF(SCK_HALF)
  ) u_sck (
    .clk (clk),
    .rst (rst),
    .en  (sck_en),
    .sck (adc_sck),
    .rise(sck_rise),
    .fall(sck_fall)
  );

  // tmr runs from CONVST entry: CONVST holds 2 cycles, WAIT a further
  // CONV_CYCLES, so the frame lasts 2 + CONV_CYCLES + 24*SCK_HALF + 1 clk
  // and the registered dout_valid lands one cycle after DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (tick) state_next = CONVST;
      CONVST:  if (tmr == TMR_W'(1)) state_next = WAIT;
      WAIT:    if (tmr == TMR_W'(CONV_CYCLES + 1)) state_next = SHIFT;
      SHIFT:   if (sck_fall && (fall_cnt == 4'd11)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      per_cnt    <= '0;
      tmr        <= '0;
      fall_cnt   <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      adc_dout   <= '1;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_next;
      dout_valid <= 1'b0;

      if (!enable || (per_cnt == PER_W'(SAMPLE_PERIOD - 1))) begin
        per_cnt <= '0;
      end else begin
        per_cnt <= per_cnt + PER_W'(1);
      end

      if ((state == CONVST) || (state == WAIT)) begin
        tmr <= tmr + TMR_W'(1);
      end else begin
        tmr <= '0;
      end

      // Config bits sit in the top of a 12-bit register so SDI drops to 0
      // by itself once the six config bits have been shifted out.
      if ((state == WAIT) && (state_next == SHIFT)) begin
        tx_sr    <= {cfg_word(CHANNEL), {(ADC_W - CFG_W){1'b0}}};
        fall_cnt <= '0;
      end else if (sck_fall) begin
        tx_sr    <= {tx_sr[ADC_W-2:0], 1'b0};
        fall_cnt <= fall_cnt + 4'd1;
      end

      if (sck_rise) begin
        rx_sr <= {rx_sr[ADC_W-2:0], adc_sdo};
      end

      if (state == DONE) begin
        if (smp_cnt == CNT_LAST) begin
          adc_dout   <= acc_sum[ACC_W-1:AVG_LOG2];
          dout_valid <= 1'b1;
          acc        <= '0;
          smp_cnt    <= '0;
        end else begin
          acc     <= acc_sum;
          smp_cnt <= smp_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
module tb_adc_ltc2308_ctrl;

  localparam int H    = 2;
  localparam int CONV = 10;
  localparam int PER  = 200;
  localparam int LAT  = 2 + CONV + 24 * H + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: AVG_LOG2=0, CHANNEL=5; 1: AVG_LOG2=2, CHANNEL=0; 2: AVG_LOG2=4, CHANNEL=3
  logic        rst    [3] = '{1'b1, 1'b1, 1'b1};
  logic        enable [3] = '{1'b0, 1'b0, 1'b0};
  logic        convst [3];
  logic        sck    [3];
  logic        sdi    [3];
  logic        sdo    [3] = '{1'b0, 1'b0, 1'b0};
  logic        valid  [3];
  logic        busy   [3];
  logic [11:0] dout   [3];

  adc_ltc2308_ctrl #(.SCK_HALF(H), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(PER),
                     .CHANNEL(3'd5), .AVG_LOG2(0)) dut0 (
    .clk(clk), .rst(rst[0]), .enable(enable[0]), .adc_convst(convst[0]), .adc_sck(sck[0]),
    .adc_sdi(sdi[0]), .adc_sdo(sdo[0]), .adc_dout(dout[0]), .dout_valid(valid[0]), .busy(busy[0]));

  adc_ltc2308_ctrl #(.SCK_HALF(H), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(PER),
                     .CHANNEL(3'd0), .AVG_LOG2(2)) dut1 (
    .clk(clk), .rst(rst[1]), .enable(enable[1]), .adc_convst(convst[1]), .adc_sck(sck[1]),
    .adc_sdi(sdi[1]), .adc_sdo(sdo[1]), .adc_dout(dout[1]), .dout_valid(valid[1]), .busy(busy[1]));

  adc_ltc2308_ctrl #(.SCK_HALF(H), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(PER),
                     .CHANNEL(3'd3), .AVG_LOG2(4)) dut2 (
    .clk(clk), .rst(rst[2]), .enable(enable[2]), .adc_convst(convst[2]), .adc_sck(sck[2]),
    .adc_sdi(sdi[2]), .adc_sdo(sdo[2]), .adc_dout(dout[2]), .dout_valid(valid[2]), .busy(busy[2]));

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Codes the ADC model returns, one per CONVST, in order.
  logic [11:0] codes [3][$];

  int          rd_idx        [3] = '{0, 0, 0};
  int          bit_i         [3] = '{12, 12, 12};
  logic [11:0] cur_code      [3] = '{12'd0, 12'd0, 12'd0};
  int          cs_count      [3] = '{0, 0, 0};
  int          cs_start      [3] = '{0, 0, 0};
  int          cs_width      [3] = '{0, 0, 0};
  int          bad_width     [3] = '{0, 0, 0};
  int          rises         [3] = '{0, 0, 0};
  int          vcount        [3] = '{0, 0, 0};
  int          v_cyc         [3] = '{0, 0, 0};
  int          silent_change [3] = '{0, 0, 0};
  logic [11:0] sdi_cap       [3] = '{12'd0, 12'd0, 12'd0};
  logic [11:0] last_dout     [3] = '{12'd0, 12'd0, 12'd0};
  logic        prev_cs       [3] = '{1'b0, 1'b0, 1'b0};
  logic        prev_sck      [3] = '{1'b0, 1'b0, 1'b0};

  // LTC2308 model plus observers: the ADC latches a code at CONVST and
  // presents it MSB first, advancing one bit per SCK fall.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (convst[g] && !prev_cs[g]) begin
        cur_code[g] = (rd_idx[g] < codes[g].size()) ? codes[g][rd_idx[g]] : 12'd0;
        rd_idx[g]++;
        bit_i[g] = 0;
        cs_count[g]++;
        cs_start[g] = cyc;
        cs_width[g] = 1;
        rises[g] = 0;
      end else if (convst[g]) begin
        cs_width[g]++;
      end else if (prev_cs[g] && cs_width[g] != 2) begin
        bad_width[g]++;
      end
      if (!sck[g] && prev_sck[g] && bit_i[g] < 12) bit_i[g]++;
      if (sck[g] && !prev_sck[g]) begin
        if (rises[g] < 12) sdi_cap[g][11 - rises[g]] = sdi[g];
        rises[g]++;
      end
      sdo[g] = (bit_i[g] < 12) ? cur_code[g][11 - bit_i[g]] : 1'b0;
      if (valid[g]) begin
        vcount[g]++;
        v_cyc[g] = cyc;
      end else if (!rst[g] && dout[g] !== last_dout[g]) begin
        silent_change[g]++;
      end
      last_dout[g] = dout[g];
      prev_cs[g]  = convst[g];
      prev_sck[g] = sck[g];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int g, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (vcount[g] >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cs(input int g, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (cs_count[g] >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick(3);
    for (int g = 0; g < 3; g++) begin
      n_assert++; if ({convst[g], sck[g], sdi[g], valid[g], busy[g]} !== 5'b0) begin n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b required 00000", g, {convst[g], sck[g], sdi[g], valid[g], busy[g]}); end
      n_assert++; if (dout[g] !== 12'd4095) begin n_fail++;
        $display("FAIL reset_dout[%0d]: got %0d required 4095", g, dout[g]); end
    end
    for (int g = 0; g < 3; g++) rst[g] = 1'b0;
    tick(20);
    n_assert++; if (cs_count[0] + cs_count[1] + cs_count[2] !== 0) begin n_fail++;
      $display("FAIL idle_disabled: got %0d CONVST pulses required 0", cs_count[0] + cs_count[1] + cs_count[2]); end
  endtask

  task automatic test_single_sample;
    int bv, bc;
    bit ok;
    bv = vcount[0]; bc = cs_count[0];
    codes[0].push_back(12'd3550);
    enable[0] = 1'b1;
    wait_cs(0, bc + 1, 10, ok);
    enable[0] = 1'b0;
    n_assert++; if (!ok) begin n_fail++; $display("FAIL single_start: got no CONVST required one"); end
    wait_valid(0, bv + 1, LAT + 20, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL single_valid: got no dout_valid required one"); end
    tick(PER + 20);
    n_assert++; if (cs_count[0] !== bc + 1 || cs_width[0] !== 2) begin n_fail++;
      $display("FAIL single_convst: got %0d pulses width %0d required 1 pulse width 2", cs_count[0] - bc, cs_width[0]); end
    n_assert++; if (rises[0] !== 12) begin n_fail++; $display("FAIL single_sck_rises: got %0d required 12", rises[0]); end
    n_assert++; if (vcount[0] !== bv + 1) begin n_fail++;
      $display("FAIL single_valid_count: got %0d required 1", vcount[0] - bv); end
    n_assert++; if (dout[0] !== 12'd3550) begin n_fail++; $display("FAIL single_dout: got %0d required 3550", dout[0]); end
    n_assert++; if (v_cyc[0] - cs_start[0] !== LAT) begin n_fail++;
      $display("FAIL single_latency: got %0d required %0d", v_cyc[0] - cs_start[0], LAT); end
  endtask

  task automatic test_config_word;
    int bv, bc;
    bit ok;
    logic [2:0] ch;
    logic [5:0] exp_cfg;
    logic [11:0] code;
    ch = 3'd5;
    exp_cfg = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    code = 12'($urandom_range(0, 4095));
    bv = vcount[0]; bc = cs_count[0];
    codes[0].push_back(code);
    enable[0] = 1'b1;
    wait_cs(0, bc + 1, 10, ok);
    enable[0] = 1'b0;
    wait_valid(0, bv + 1, LAT + 20, ok);
    n_assert++; if (!ok) begin n_fail++; $display("FAIL cfg_valid: got no dout_valid required one"); end
    n_assert++; if (sdi_cap[0][11:6] !== exp_cfg) begin n_fail++;
      $display("FAIL cfg_bits: got %b required %b", sdi_cap[0][11:6], exp_cfg); end
    n_assert++; if (sdi_cap[0][5:0] !== 6'b0) begin n_fail++;
      $display("FAIL cfg_tail: got %b required 000000", sdi_cap[0][5:0]); end
    n_assert++; if (dout[0] !== code) begin n_fail++; $display("FAIL cfg_dout: got %0d required %0d", dout[0], code); end
    tick(PER);
  endtask

  task automatic test_average;
    int bv, bc;
    bit ok;
    int unsigned sum;
    logic [11:0] c [4];
    c = '{12'd3600, 12'd3601, 12'd3602, 12'd3604};
    sum = 0;
    for (int i = 0; i < 4; i++) begin codes[1].push_back(c[i]); sum += c[i]; end
    bv = vcount[1]; bc = cs_count[1];
    enable[1] = 1'b1;
    wait_valid(1, bv + 1, 4 * PER + 200, ok);
    enable[1] = 1'b0;
    n_assert++; if (!ok) begin n_fail++; $display("FAIL avg_valid: got no dout_valid required one"); end
    n_assert++; if (cs_count[1] !== bc + 4) begin n_fail++;
      $display("FAIL avg_frames: got %0d frames before dout_valid required 4", cs_count[1] - bc); end
    n_assert++; if (dout[1] !== 12'(sum / 4)) begin n_fail++; $display("FAIL avg_dout: got %0d required %0d", dout[1], sum / 4); end
    n_assert++; if (v_cyc[1] - cs_start[1] !== LAT) begin n_fail++;
      $display("FAIL avg_latency: got %0d required %0d", v_cyc[1] - cs_start[1], LAT); end
    tick(PER);
  endtask

  task automatic test_random_average;
    int bv;
    bit ok;
    int unsigned exp_avg [3];
    for (int r = 0; r < 3; r++) begin
      int unsigned sum = 0;
      for (int i = 0; i < 4; i++) begin
        logic [11:0] c = 12'($urandom_range(0, 4095));
        codes[1].push_back(c);
        sum += c;
      end
      exp_avg[r] = sum / 4;
    end
    bv = vcount[1];
    enable[1] = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_valid(1, bv + r + 1, 4 * PER + 200, ok);
      n_assert++; if (!ok || dout[1] !== 12'(exp_avg[r])) begin n_fail++;
        $display("FAIL rand_avg[%0d]: got %0d required %0d", r, dout[1], exp_avg[r]); end
    end
    enable[1] = 1'b0;
    tick(PER);
  endtask

  task automatic test_enable_drop;
    int bv, bc, e;
    bit ok;
    int unsigned sum = 0;
    for (int i = 0; i < 4; i++) begin
      logic [11:0] c = 12'($urandom_range(0, 4000));
      codes[1].push_back(c);
      sum += c;
    end
    bv = vcount[1]; bc = cs_count[1];
    enable[1] = 1'b1;
    wait_cs(1, bc + 2, 2 * PER + 20, ok);
    tick(4);
    enable[1] = 1'b0;
    n_assert++; if (!ok || busy[1] !== 1'b1) begin n_fail++;
      $display("FAIL drop_in_wait: got busy=%b required 1 in second frame", busy[1]); end
    tick(LAT + 3 * PER);
    n_assert++; if (rises[1] !== 12 || busy[1] !== 1'b0) begin n_fail++;
      $display("FAIL drop_frame_done: got %0d rises busy=%b required 12 rises busy=0", rises[1], busy[1]); end
    n_assert++; if (cs_count[1] !== bc + 2 || vcount[1] !== bv) begin n_fail++;
      $display("FAIL drop_idle: got %0d frames %0d valids required 2 frames 0 valids", cs_count[1] - bc, vcount[1] - bv); end
    e = cyc;
    enable[1] = 1'b1;
    wait_cs(1, bc + 3, 10, ok);
    n_assert++; if (!ok || cs_start[1] !== e + 1) begin n_fail++;
      $display("FAIL resume_start: got cycle %0d required %0d", cs_start[1], e + 1); end
    wait_cs(1, bc + 4, PER + 10, ok);
    n_assert++; if (!ok || cs_start[1] !== e + 1 + PER) begin n_fail++;
      $display("FAIL resume_period: got cycle %0d required %0d", cs_start[1], e + 1 + PER); end
    wait_valid(1, bv + 1, LAT + 20, ok);
    enable[1] = 1'b0;
    n_assert++; if (!ok || dout[1] !== 12'(sum / 4)) begin n_fail++;
      $display("FAIL resume_avg: got %0d required %0d", dout[1], sum / 4); end
    tick(PER);
  endtask

  task automatic test_reset_mid_shift;
    int bv, bc;
    bit ok;
    int unsigned sum = 0;
    logic [11:0] c [4];
    for (int i = 0; i < 3; i++) codes[1].push_back(12'd4095);
    bv = vcount[1]; bc = cs_count[1];
    enable[1] = 1'b1;
    wait_cs(1, bc + 3, 3 * PER + 20, ok);
    for (int i = 0; i < 4 * LAT && !(rises[1] >= 8 && sck[1]); i++) tick(1);
    n_assert++; if (!(rises[1] == 8 && sck[1])) begin n_fail++;
      $display("FAIL rst_reach_bit7: got %0d rises required 8 with sck high", rises[1]); end
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    n_assert++; if ({sck[1], busy[1], valid[1]} !== 3'b000) begin n_fail++;
      $display("FAIL rst_mid_ctrl: got sck/busy/valid=%b required 000", {sck[1], busy[1], valid[1]}); end
    n_assert++; if (dout[1] !== 12'd4095) begin n_fail++; $display("FAIL rst_mid_dout: got %0d required 4095", dout[1]); end
    c = '{12'd100, 12'd200, 12'd300, 12'd401};
    for (int i = 0; i < 4; i++) begin codes[1].push_back(c[i]); sum += c[i]; end
    tick(2);
    rst[1] = 1'b0;
    wait_valid(1, bv + 1, 4 * PER + 200, ok);
    enable[1] = 1'b0;
    n_assert++; if (!ok || dout[1] !== 12'(sum / 4)) begin n_fail++;
      $display("FAIL rst_clean_avg: got %0d required %0d", dout[1], sum / 4); end
    tick(PER);
    n_assert++; if (vcount[1] !== bv + 1) begin n_fail++;
      $display("FAIL rst_valid_count: got %0d required 1", vcount[1] - bv); end
  endtask

  task automatic test_extremes;
    int bv;
    bit ok;
    for (int i = 0; i < 16; i++) codes[2].push_back(12'd0);
    for (int i = 0; i < 16; i++) codes[2].push_back(12'd4095);
    bv = vcount[2];
    enable[2] = 1'b1;
    wait_valid(2, bv + 1, 16 * PER + 200, ok);
    n_assert++; if (!ok || dout[2] !== 12'd0) begin n_fail++; $display("FAIL extreme_zero: got %0d required 0", dout[2]); end
    wait_valid(2, bv + 2, 16 * PER + 200, ok);
    enable[2] = 1'b0;
    n_assert++; if (!ok || dout[2] !== 12'd4095) begin n_fail++; $display("FAIL extreme_full: got %0d required 4095", dout[2]); end
    n_assert++; if (v_cyc[2] - cs_start[2] !== LAT) begin n_fail++;
      $display("FAIL extreme_latency: got %0d required %0d", v_cyc[2] - cs_start[2], LAT); end
    tick(PER);
  endtask

  task automatic test_invariants;
    for (int g = 0; g < 3; g++) begin
      n_assert++; if (silent_change[g] !== 0) begin n_fail++;
        $display("FAIL dout_hold[%0d]: got %0d changes without dout_valid required 0", g, silent_change[g]); end
      n_assert++; if (bad_width[g] !== 0) begin n_fail++;
        $display("FAIL convst_width[%0d]: got %0d pulses not 2 clk wide required 0", g, bad_width[g]); end
    end
  endtask

  initial begin
    test_reset;
    test_single_sample;
    test_config_word;
    test_average;
    test_random_average;
    test_enable_drop;
    test_reset_mid_shift;
    test_extremes;
    test_invariants;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
